// File: rtl/ahb_slave_mem_if.sv
// Simplified AHB master/slave signal bundle for the memory responder.
`include "const_defines.svh"

interface ahb_slave_mem_if;
    logic                       hsel;
    logic [`AHB_ADDR_WIDTH-1:0] haddr;
    logic                       haddr_ctrl;
    logic                       hwrite;
    logic [`AHB_DATA_WIDTH-1:0] hwdata;
    logic [`AHB_DATA_WIDTH-1:0] hdata_s2m;
    logic                       hready_s2m;
    logic                       hresp_s2m;

    modport master (
        output hsel, haddr, haddr_ctrl, hwrite, hwdata,
        input  hdata_s2m, hready_s2m, hresp_s2m
    );

    modport slave (
        input  hsel, haddr, haddr_ctrl, hwrite, hwdata,
        output hdata_s2m, hready_s2m, hresp_s2m
    );
endinterface

// File: rtl/const_defines.svh
// Bus width definitions shared by the simplified AHB blocks.
`ifndef CONST_DEFINES_SVH
`define CONST_DEFINES_SVH
`define AHB_ADDR_WIDTH 32
`define AHB_DATA_WIDTH 32
`endif

// File: rtl/ahb_slave_mem.sv
// AHB word-memory responder with programmable wait states and two-cycle ERROR.
// state | meaning
// IDLE  | no data phase pending, ready for an address phase
// DATA  | OKAY data phase, wait counter running down to the completing cycle
// ERR1  | first ERROR cycle (hready low)
// ERR2  | second ERROR cycle (hready high, may take the next address phase)
`include "const_defines.svh"

module ahb_slave_mem #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            rstn,
    ahb_slave_mem_if.slave  bus
);

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [3:0]                 wait_cnt;
    logic [3:0]                 wait_cnt_nxt;
    logic [IDX_W-1:0]           idx_q;
    logic                       write_q;
    logic                       ready;
    logic                       accept;
    logic                       bad_addr;
    logic                       mem_we;
    logic [`AHB_DATA_WIDTH-1:0] mem [DEPTH];

    // Handshake outputs depend only on registered state, never on bus inputs.
    assign ready = (state == IDLE) || (state == ERR2) ||
                   ((state == DATA) && (wait_cnt == 4'd0));
    assign bus.hready_s2m = ready;
    assign bus.hresp_s2m  = (state == ERR1) || (state == ERR2);
    assign bus.hdata_s2m  = ((state == DATA) && (wait_cnt == 4'd0) && !write_q)
                            ? mem[idx_q] : '0;

    assign accept   = bus.hsel & bus.haddr_ctrl & ready;
    assign bad_addr = (bus.haddr[1:0] != 2'b00) ||
                      ((bus.haddr >> (IDX_W + 2)) != '0);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_we       = 1'b0;
        case (state)
            IDLE: state_nxt = IDLE;
            DATA: begin
                if (wait_cnt != 4'd0) begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end else begin
                    mem_we    = write_q;
                    state_nxt = IDLE;
                end
            end
            ERR1: state_nxt = ERR2;
            ERR2: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A completing cycle can take the next address phase with no bubble.
        if (accept) begin
            state_nxt    = bad_addr ? ERR1 : DATA;
            wait_cnt_nxt = bad_addr ? 4'd0 : WAIT_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            idx_q    <= '0;
            write_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                idx_q   <= bus.haddr[2 +: IDX_W];
                write_q <= bus.hwrite;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && mem_we) begin
            mem[idx_q] <= bus.hwdata;
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: four instances (WAIT_STATES 0..3) share one stimulus
// stream and are checked against a transaction-level model plus directed vectors.
module tb_ahb_slave_mem;

    logic        clk;
    logic        rstn;
    logic        sel;
    logic        ctrl;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [3:0]        rdy;
    logic [3:0]        resp;
    logic [3:0][31:0]  dat;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ahb_slave_mem_if bus_i ();
        assign bus_i.hsel       = sel;
        assign bus_i.haddr      = addr;
        assign bus_i.haddr_ctrl = ctrl;
        assign bus_i.hwrite     = wr;
        assign bus_i.hwdata     = wdata;
        assign rdy[g]           = bus_i.hready_s2m;
        assign resp[g]          = bus_i.hresp_s2m;
        assign dat[g]           = bus_i.hdata_s2m;

        ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(g)) u_dut (
            .clk  (clk),
            .rstn (rstn),
            .bus  (bus_i.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level reference: each accepted transfer occupies a data phase of
    // known length (WAIT_STATES+1 for OKAY, 2 for ERROR); its last cycle completes it.
    bit          m_act   [4];
    int          m_age   [4];
    bit          m_wr    [4];
    bit          m_bad   [4];
    int          m_idx   [4];
    logic [31:0] m_mem   [4][256];
    bit          m_known [4][256];
    logic [31:0] got_rd  [4];

    function automatic int plen(input int i);
        return m_bad[i] ? 2 : i + 1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            bit last;
            bit free;
            if (!rstn) begin
                m_act[i] = 1'b0;
            end else begin
                last = m_act[i] && (m_age[i] == plen(i) - 1);
                free = !m_act[i] || last;
                if (last) begin
                    if (!m_bad[i] && m_wr[i]) begin
                        m_mem[i][m_idx[i]]   = wdata;
                        m_known[i][m_idx[i]] = 1'b1;
                    end
                    m_act[i] = 1'b0;
                end else if (m_act[i]) begin
                    m_age[i] = m_age[i] + 1;
                end
                if (free && sel && ctrl) begin
                    m_act[i] = 1'b1;
                    m_age[i] = 0;
                    m_wr[i]  = wr;
                    m_idx[i] = int'(addr[9:2]);
                    m_bad[i] = (addr[1:0] != 2'b00) || (addr[31:10] != 22'd0);
                end
            end
        end
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got 0x%08h want 0x%08h", nm, inst, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                bit last;
                bit rd_done;
                last    = m_act[i] && (m_age[i] == plen(i) - 1);
                rd_done = last && !m_bad[i] && !m_wr[i];
                chk("model_hready", i, 32'(rdy[i]), 32'(!m_act[i] || last));
                chk("model_hresp",  i, 32'(resp[i]), 32'(m_act[i] && m_bad[i]));
                if (rd_done) begin
                    got_rd[i] = dat[i];
                    if (m_known[i][m_idx[i]])
                        chk("model_rdata", i, dat[i], m_mem[i][m_idx[i]]);
                end else begin
                    chk("model_hdata_zero", i, dat[i], 32'h0);
                end
            end
        end
    end

    typedef struct {
        bit          sel;
        bit          ctrl;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          rdy;
        bit          resp;
        logic [31:0] data;
    } vec_t;

    vec_t vt[6];

    task automatic drv(input bit s, input bit c, input bit w, input logic [31:0] a,
                       input logic [31:0] d);
        sel   = s;
        ctrl  = c;
        wr    = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic drain(input int n);
        sel  = 1'b0;
        ctrl = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic single(input bit w, input logic [31:0] a, input logic [31:0] d);
        drv(1'b1, 1'b1, w, a, d);
        @(negedge clk);
        drain(6);
    endtask

    initial begin
        // Single write then read on the WAIT_STATES=1 instance, one row per cycle.
        vt[0] = '{1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 32'h00, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        vt[2] = '{1'b1, 1'b0, 1'b0, 32'h00, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        vt[3] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vt[4] = '{1'b1, 1'b0, 1'b0, 32'h00, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF};
        vt[5] = '{1'b1, 1'b0, 1'b0, 32'h00, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};

        rstn = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_hready", i, 32'(rdy[i]), 32'h1);
            chk("rst_hresp",  i, 32'(resp[i]), 32'h0);
            chk("rst_hdata",  i, dat[i], 32'h0);
        end
        rstn = 1'b1;

        for (int r = 0; r < 6; r++) begin
            drv(vt[r].sel, vt[r].ctrl, vt[r].wr, vt[r].addr, vt[r].wdata);
            @(negedge clk);
            chk("tbl_hready", 1, 32'(rdy[1]), 32'(vt[r].rdy));
            chk("tbl_hresp",  1, 32'(resp[1]), 32'(vt[r].resp));
            chk("tbl_hdata",  1, dat[1], vt[r].data);
        end
        drain(6);

        // Pipelined burst: WAIT_STATES=0 instance never deasserts hready.
        drv(1'b1, 1'b1, 1'b1, 32'h0, 32'h0);       @(negedge clk);
        chk("burst_hready", 0, 32'(rdy[0]), 32'h1);
        drv(1'b1, 1'b1, 1'b1, 32'h4, 32'h11);      @(negedge clk);
        chk("burst_hready", 0, 32'(rdy[0]), 32'h1);
        drv(1'b1, 1'b1, 1'b1, 32'h8, 32'h22);      @(negedge clk);
        chk("burst_hready", 0, 32'(rdy[0]), 32'h1);
        drv(1'b1, 1'b1, 1'b0, 32'h0, 32'h33);      @(negedge clk);
        chk("burst_hready", 0, 32'(rdy[0]), 32'h1);
        chk("burst_rd0", 0, dat[0], 32'h11);
        drv(1'b1, 1'b1, 1'b0, 32'h4, 32'h33);      @(negedge clk);
        chk("burst_rd1", 0, dat[0], 32'h22);
        drv(1'b1, 1'b1, 1'b0, 32'h8, 32'h33);      @(negedge clk);
        chk("burst_rd2", 0, dat[0], 32'h33);
        chk("burst_hready", 0, 32'(rdy[0]), 32'h1);
        drain(6);

        // ERROR responses: out-of-range read, then misaligned write aliasing word 0.
        for (int e = 0; e < 2; e++) begin
            if (e == 0) drv(1'b1, 1'b1, 1'b0, 32'h400, 32'h0);
            else        drv(1'b1, 1'b1, 1'b1, 32'h402, 32'hBADC0DE0);
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                chk("err1_hready", i, 32'(rdy[i]), 32'h0);
                chk("err1_hresp",  i, 32'(resp[i]), 32'h1);
            end
            drain(1);
            for (int i = 0; i < 4; i++) begin
                chk("err2_hready", i, 32'(rdy[i]), 32'h1);
                chk("err2_hresp",  i, 32'(resp[i]), 32'h1);
            end
            drain(1);
            chk("err_done_hresp", 0, 32'(resp[0]), 32'h0);
            drain(4);
        end
        drv(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("err_mem_kept", 0, dat[0], 32'h11);
        drain(6);

        // Back-to-back write then read of the same word.
        drv(1'b1, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5); @(negedge clk);
        drv(1'b1, 1'b1, 1'b0, 32'h20, 32'hA5A5A5A5); @(negedge clk);
        chk("b2b_rd", 0, dat[0], 32'hA5A5A5A5);
        drain(6);

        // Address phase offered while hready is low must be ignored.
        single(1'b1, 32'h80, 32'h12345678);
        drv(1'b1, 1'b1, 1'b1, 32'h40, 32'h0F0F0F0F); @(negedge clk);
        for (int i = 1; i < 4; i++) chk("busy_hready", i, 32'(rdy[i]), 32'h0);
        drv(1'b1, 1'b1, 1'b1, 32'h80, 32'h0F0F0F0F); @(negedge clk);
        drain(6);
        single(1'b0, 32'h80, 32'h0);
        for (int i = 1; i < 4; i++) chk("ignored_phase", i, got_rd[i], 32'h12345678);
        chk("taken_phase", 0, got_rd[0], 32'h0F0F0F0F);

        // Reset in the middle of a write drops it.
        single(1'b1, 32'h40, 32'h5555AAAA);
        drv(1'b1, 1'b1, 1'b1, 32'h40, 32'hBADBAD00); @(negedge clk);
        rstn = 1'b0;
        sel  = 1'b0;
        ctrl = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_hready", i, 32'(rdy[i]), 32'h1);
            chk("midrst_hresp",  i, 32'(resp[i]), 32'h0);
            chk("midrst_hdata",  i, dat[i], 32'h0);
        end
        @(negedge clk);
        rstn = 1'b1;
        drain(2);
        single(1'b0, 32'h40, 32'h0);
        chk("abort_no_write", 3, got_rd[3], 32'h5555AAAA);
        chk("abort_no_write", 0, got_rd[0], 32'h5555AAAA);

        // Random traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            rstn  = ($urandom_range(0, 149) != 0);
            sel   = ($urandom_range(0, 3) != 0);
            ctrl  = ($urandom_range(0, 2) != 0);
            wr    = $urandom_range(0, 1) == 1;
            wdata = $urandom;
            if ($urandom_range(0, 7) == 0) addr = $urandom & 32'h0000_0FFF;
            else                           addr = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
            @(negedge clk);
        end
        rstn = 1'b1;
        drain(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
